serial_divisibility_controller: RTL and testbench

SERIAL_DIVISIBILITY_CONTROLLER -- requirements
Module: serial_divisibility_controller

---
 rtl/serial_divisibility_pkg.sv | 13 +
 rtl/serial_divisibility_controller_serial_remainder_fsm.sv | 34 +++
 rtl/serial_divisibility_controller.sv | 102 ++++++++++
 tb/tb_serial_divisibility_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_divisibility_pkg.sv
// Shared types and default sizes for the serial divisibility controller.
package serial_divisibility_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_divisibility_controller_serial_remainder_fsm.sv
// Running remainder of a bit-serial operand, one conditional subtract per bit.
module serial_remainder_fsm #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             new_bit,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] remainder
);

    logic [DIV_W:0] t;

    assign t = {remainder, new_bit};

    // remainder < divisor keeps t below 2*divisor, so one subtract is enough;
    // a zero divisor pins the remainder at 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            remainder <= '0;
        end else if (enable) begin
            if (divisor == '0) begin
                remainder <= '0;
            end else if (t >= {1'b0, divisor}) begin
                remainder <= DIV_W'(t - {1'b0, divisor});
            end else begin
                remainder <= t[DIV_W-1:0];
            end
        end
    end

endmodule

// File: rtl/serial_divisibility_controller.sv
// Handshaked controller: accepts an operand/divisor pair, shifts the operand
// MSB first through the remainder engine and presents the verdict.
module serial_divisibility_controller
    import serial_divisibility_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DIV_W-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_divisible,
    output logic [DIV_W-1:0] out_remainder,
    output logic             out_error,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   count;
    logic [DIV_W-1:0]   div_reg;
    logic [DIV_W-1:0]   remainder;
    logic               rem_clear;
    logic               rem_enable;

    assign rem_clear  = (state == IDLE) && in_valid;
    assign rem_enable = (state == SHIFT);

    serial_remainder_fsm #(
        .DIV_W (DIV_W)
    ) u_remainder (
        .clk       (clk),
        .rst       (rst),
        .clear     (rem_clear),
        .enable    (rem_enable),
        .new_bit   (shift_reg[WIDTH-1]),
        .divisor   (div_reg),
        .remainder (remainder)
    );

    // out_valid rises one cycle after entering DONE, so results appear
    // WIDTH+1 edges after acceptance; the remainder is frozen outside SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            div_reg   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        div_reg   <= in_divisor;
                        count     <= CNT_W'(WIDTH - 1);
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    count     <= count - 1'b1;
                    if (count == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_remainder = out_valid ? remainder : '0;
    assign out_error     = out_valid && (div_reg == '0);
    assign out_divisible = out_valid && (div_reg != '0) && (remainder == '0);

endmodule

// File: tb/tb_serial_divisibility_controller.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// random back-to-back run, all checked through an expected-result queue.
module tb_serial_divisibility_controller;

    localparam int WIDTH = 8;
    localparam int DIV_W = 4;
    localparam int LATENCY = WIDTH + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [DIV_W-1:0] divisor;
        logic [DIV_W-1:0] rem;
        logic             divisible;
        logic             error;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [DIV_W-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic             out_divisible;
    logic [DIV_W-1:0] out_remainder;
    logic             out_error;
    logic             busy;

    int   compared = 0;
    int   mismatched = 0;
    vec_t exp_q[$];
    vec_t table_v[9];

    serial_divisibility_controller #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_divisor    (in_divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_divisible (out_divisible),
        .out_remainder (out_remainder),
        .out_error     (out_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t model(input logic [WIDTH-1:0] d, input logic [DIV_W-1:0] v);
        vec_t e;
        e.data    = d;
        e.divisor = v;
        if (v == 0) begin
            e.rem       = '0;
            e.error     = 1'b1;
            e.divisible = 1'b0;
        end else begin
            e.rem       = DIV_W'(int'(d) % int'(v));
            e.error     = 1'b0;
            e.divisible = (e.rem == 0);
        end
        return e;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid   = 1'b1;
        in_data    = v.data;
        in_divisor = v.divisor;
        exp_q.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic check_output(input int hold_cycles);
        int   lat = 0;
        vec_t e;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, LATENCY);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("remainder", int'(out_remainder), int'(e.rem));
        check("divisible", int'(out_divisible), int'(e.divisible));
        check("error", int'(out_error), int'(e.error));
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_remainder", int'(out_remainder), int'(e.rem));
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_after_handshake", int'(out_valid), 0);
        check("remainder_gated", int'(out_remainder), 0);
    endtask

    initial begin
        vec_t v;
        int   spurious;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_divisor = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_remainder", int'(out_remainder), 0);
        rst = 1'b0;

        table_v[0] = '{8'h0F, 4'd5,  4'd0,  1'b1, 1'b0};
        table_v[1] = '{8'h0E, 4'd3,  4'd2,  1'b0, 1'b0};
        table_v[2] = '{8'hFF, 4'd1,  4'd0,  1'b1, 1'b0};
        table_v[3] = '{8'hA7, 4'd0,  4'd0,  1'b0, 1'b1};
        table_v[4] = '{8'h00, 4'd7,  4'd0,  1'b1, 1'b0};
        table_v[5] = '{8'hFF, 4'd15, 4'd0,  1'b1, 1'b0};
        table_v[6] = '{8'h64, 4'd9,  4'd1,  1'b0, 1'b0};
        table_v[7] = '{8'h80, 4'd13, 4'd11, 1'b0, 1'b0};
        table_v[8] = '{8'h01, 4'd2,  4'd1,  1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(table_v[i]);
            check_output(0);
        end

        // Result held under out_ready=0 while a new pair is offered.
        apply_stimulus('{8'h2D, 4'd6, 4'd3, 1'b0, 1'b0});
        in_valid   = 1'b1;
        in_data    = 8'h0A;
        in_divisor = 4'd4;
        check_output(5);
        check("idle_after_handshake", int'(busy), 0);
        apply_stimulus('{8'h0A, 4'd4, 4'd2, 1'b0, 1'b0});
        check_output(0);

        // Abort in the 4th SHIFT cycle; no result may follow.
        in_valid   = 1'b1;
        in_data    = 8'h33;
        in_divisor = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) spurious++;
        end
        check("abort_no_result", spurious, 0);
        apply_stimulus('{8'h19, 4'd5, 4'd0, 1'b1, 1'b0});
        check_output(0);

        for (int i = 0; i < 48; i++) begin
            v = model(WIDTH'($urandom_range(0, 255)), DIV_W'(i % 16));
            apply_stimulus(v);
            check_output(0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
